// File: rtl/imem_fetch_responder.sv
// Instruction memory with a program-load phase followed by a run phase that
// serves 64-bit fetch windows (aligned or halfword-offset) with one cycle latency.
module imem_fetch_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] imem_addr,
  output logic [63:0] instr,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_addr,
  input  logic [31:0] load_data,
  input  logic        load_done,
  output logic        running,
  output logic [15:0] load_cnt,
  output logic        fetch_err
);

  localparam int          AW       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN     = 33'(DEPTH_WORDS) << 2;
  localparam logic [63:0] NOP_PAIR = 64'h00000013_00000013;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic [63:0] instr_q, instr_d;
  logic [15:0] load_cnt_q, load_cnt_d;
  logic        fetch_err_q, fetch_err_d;

  // Contents survive reset so a program can be rerun without reloading.
  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0]   ld_off_s;
  logic [31:0]   f_off_s;
  logic          accept_s;
  logic          wr_en_s;
  logic [AW-1:0] wr_idx_s;
  logic          fetch_bad_s;
  logic [AW-1:0] w0_s, w1_s, w2_s;

  // Address decode for load writes and fetch reads.
  always_comb begin
    ld_off_s    = load_addr - BASE_ADDR;
    wr_idx_s    = ld_off_s[AW+1:2];
    accept_s    = load_valid & (state_q == ST_LOAD) & resetn;
    wr_en_s     = accept_s & ({1'b0, ld_off_s} < SPAN);
    f_off_s     = imem_addr - BASE_ADDR;
    fetch_bad_s = ({1'b0, f_off_s} >= SPAN) | imem_addr[0];
    w0_s        = f_off_s[AW+1:2];
    w1_s        = w0_s + AW'(1);
    w2_s        = w0_s + AW'(2);
  end

  // Next-state, fetch response and counters; reset overrides everything.
  always_comb begin
    state_d     = state_q;
    instr_d     = NOP_PAIR;
    load_cnt_d  = load_cnt_q;
    fetch_err_d = fetch_err_q;
    case (state_q)
      ST_LOAD: begin
        if (accept_s && (load_cnt_q != 16'hFFFF)) begin
          load_cnt_d = load_cnt_q + 16'd1;
        end else begin
          load_cnt_d = load_cnt_q;
        end
        if (load_done) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_LOAD;
        end
      end
      ST_RUN: begin
        if (fetch_bad_s) begin
          instr_d     = NOP_PAIR;
          fetch_err_d = 1'b1;
        end else if (imem_addr[1]) begin
          instr_d = {mem[w2_s][15:0], mem[w1_s], mem[w0_s][31:16]};
        end else begin
          instr_d = {mem[w1_s], mem[w0_s]};
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
    if (!resetn) begin
      state_d     = ST_LOAD;
      instr_d     = NOP_PAIR;
      load_cnt_d  = 16'd0;
      fetch_err_d = 1'b0;
    end else begin
      state_d = state_d;
    end
  end

  // Control and response registers.
  always_ff @(posedge clk) begin
    state_q     <= state_d;
    instr_q     <= instr_d;
    load_cnt_q  <= load_cnt_d;
    fetch_err_q <= fetch_err_d;
  end

  // Program-load write port; out-of-range writes are counted but not stored.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_idx_s] <= load_data;
    end
  end

  assign instr      = instr_q;
  assign load_ready = (state_q == ST_LOAD);
  assign running    = (state_q == ST_RUN);
  assign load_cnt   = load_cnt_q;
  assign fetch_err  = fetch_err_q;

endmodule

// File: tb/tb_imem_fetch_responder.sv
// Self-checking bench: randomized loads and fetches against a byte-stream
// reference model of the instruction memory.
module tb_imem_fetch_responder;

  localparam logic [31:0] BASE   = 32'h8000_0000;
  localparam longint      BASE_L = 64'h8000_0000;
  localparam int          D      = 64;
  localparam longint      SPAN_L = 4 * D;
  localparam logic [63:0] NOP    = 64'h00000013_00000013;

  logic        clk;
  logic        resetn;
  logic [31:0] imem_addr;
  logic [63:0] instr;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] load_addr;
  logic [31:0] load_data;
  logic        load_done;
  logic        running;
  logic [15:0] load_cnt;
  logic        fetch_err;

  logic [31:0] model_mem [D];
  int          chk_cnt;
  int          pass_cnt;

  imem_fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(D)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .imem_addr  (imem_addr),
    .instr      (instr),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_done  (load_done),
    .running    (running),
    .load_cnt   (load_cnt),
    .fetch_err  (fetch_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Memory seen as a little-endian byte stream; the window is 8 bytes from the address.
  function automatic logic [63:0] model_fetch(input logic [31:0] a);
    logic [63:0] r;
    longint      off;
    longint      b;
    off = longint'(a) - BASE_L;
    if (off < 0 || off >= SPAN_L || a[0]) return NOP;
    for (int k = 0; k < 8; k++) begin
      b = (off + k) % SPAN_L;
      r[8*k +: 8] = model_mem[int'(b / 4)][8*int'(b % 4) +: 8];
    end
    return r;
  endfunction

  function automatic bit model_bad(input logic [31:0] a);
    longint off;
    off = longint'(a) - BASE_L;
    return (off < 0 || off >= SPAN_L || a[0]);
  endfunction

  // One load write during LOAD; the model stores it only when in range.
  task automatic load_word(input logic [31:0] addr, input logic [31:0] data, input logic done);
    longint off;
    load_valid = 1'b1;
    load_addr  = addr;
    load_data  = data;
    load_done  = done;
    tick();
    load_valid = 1'b0;
    load_done  = 1'b0;
    off = longint'(addr) - BASE_L;
    if (off >= 0 && off < SPAN_L) model_mem[int'(off / 4)] = data;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick();
    chk_cnt++;
    if (instr !== NOP) $display("FAIL reset_instr got=%h exp=%h", instr, NOP);
    else pass_cnt++;
    chk_cnt++;
    if ({running, load_ready, load_cnt, fetch_err} !== {1'b0, 1'b1, 16'd0, 1'b0})
      $display("FAIL reset_ctrl got run=%b rdy=%b cnt=%0d err=%b exp 0 1 0 0",
               running, load_ready, load_cnt, fetch_err);
    else pass_cnt++;
  endtask

  // First session: load words 4..63 (one with junk low address bits) plus two dropped writes.
  task automatic test_first_load();
    logic [31:0] a;
    resetn    = 1'b1;
    imem_addr = BASE + 32'd1;
    for (int i = 4; i < D; i++) begin
      a = BASE + 32'(4 * i);
      if (i == 7) a = a | 32'd3;
      load_word(a, (i == D - 1) ? 32'hAAAA_AAAA : $urandom, 1'b0);
    end
    load_word(BASE + 32'(4 * D + 20), 32'hDEAD_BEEF, 1'b0);
    load_word(BASE - 32'd4, 32'hBADC_0DE5, 1'b0);
    chk_cnt++;
    if ({load_cnt, fetch_err, running, instr} !== {16'd62, 1'b0, 1'b0, NOP})
      $display("FAIL load_phase got cnt=%0d err=%b run=%b instr=%h exp 62 0 0 %h",
               load_cnt, fetch_err, running, instr, NOP);
    else pass_cnt++;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    chk_cnt++;
    if ({running, load_ready, fetch_err, instr} !== {1'b1, 1'b0, 1'b0, NOP})
      $display("FAIL load_done got run=%b rdy=%b err=%b instr=%h exp 1 0 0 %h",
               running, load_ready, fetch_err, instr, NOP);
    else pass_cnt++;
  endtask

  // Second session: the reference program, then the fixed-address fetches.
  task automatic test_spec_fetch();
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    load_word(BASE + 32'd0,  32'h1111_1111, 1'b0);
    load_word(BASE + 32'd4,  32'h2222_2222, 1'b0);
    load_word(BASE + 32'd8,  32'h3333_3333, 1'b0);
    load_word(BASE + 32'd12, 32'h4444_4444, 1'b0);
    chk_cnt++;
    if ({load_cnt, running} !== {16'd4, 1'b0})
      $display("FAIL cnt_four got cnt=%0d run=%b exp 4 0", load_cnt, running);
    else pass_cnt++;
    load_done = 1'b1;
    tick();
    load_done = 1'b0;
    imem_addr = BASE;
    tick();
    chk_cnt++;
    if ({instr, running, load_cnt} !== {64'h22222222_11111111, 1'b1, 16'd4})
      $display("FAIL fetch_base got instr=%h run=%b cnt=%0d exp 2222222211111111 1 4",
               instr, running, load_cnt);
    else pass_cnt++;
    imem_addr = BASE + 32'd2;
    tick();
    chk_cnt++;
    if (instr !== 64'h33332222_22221111)
      $display("FAIL fetch_half got=%h exp=3333222222221111", instr);
    else pass_cnt++;
    imem_addr = BASE + 32'(4 * D - 4);
    tick();
    chk_cnt++;
    if ({instr, fetch_err} !== {64'h11111111_AAAAAAAA, 1'b0})
      $display("FAIL fetch_wrap got instr=%h err=%b exp 11111111aaaaaaaa 0", instr, fetch_err);
    else pass_cnt++;
    imem_addr = BASE + 32'(4 * D - 2);
    tick();
    chk_cnt++;
    if (instr !== model_fetch(BASE + 32'(4 * D - 2)))
      $display("FAIL fetch_wrap_half got=%h exp=%h", instr, model_fetch(BASE + 32'(4 * D - 2)));
    else pass_cnt++;
  endtask

  // A new valid fetch every cycle, compared window-by-window with the model.
  task automatic test_random_fetch(input int n, input logic exp_err);
    logic [31:0] a;
    for (int i = 0; i < n; i++) begin
      a = BASE + 32'(2 * $urandom_range(0, 2 * D - 1));
      imem_addr = a;
      tick();
      chk_cnt++;
      if ({instr, fetch_err} !== {model_fetch(a), exp_err})
        $display("FAIL rand_fetch addr=%h got instr=%h err=%b exp %h %b",
                 a, instr, fetch_err, model_fetch(a), exp_err);
      else pass_cnt++;
    end
  endtask

  task automatic test_fetch_err();
    logic [31:0] bad [3];
    bad[0] = 32'h7FFF_FFFC;
    bad[1] = BASE + 32'd1;
    bad[2] = BASE + 32'(4 * D);
    for (int i = 0; i < 3; i++) begin
      imem_addr = bad[i];
      tick();
      chk_cnt++;
      if ({instr, fetch_err} !== {NOP, model_bad(bad[i])})
        $display("FAIL fetch_bad addr=%h got instr=%h err=%b exp %h 1",
                 bad[i], instr, fetch_err, NOP);
      else pass_cnt++;
    end
    test_random_fetch(10, 1'b1);
  endtask

  task automatic test_run_ignores_load();
    load_valid = 1'b1;
    load_addr  = BASE;
    load_data  = 32'hFFFF_FFFF;
    imem_addr  = BASE;
    tick();
    load_valid = 1'b0;
    tick();
    chk_cnt++;
    if ({instr, load_cnt, load_ready} !== {model_fetch(BASE), 16'd4, 1'b0})
      $display("FAIL run_load_ignored got instr=%h cnt=%0d rdy=%b exp %h 4 0",
               instr, load_cnt, load_ready, model_fetch(BASE));
    else pass_cnt++;
  endtask

  // Reset in RUN (with a write attempt under reset), then write+done together.
  task automatic test_back_to_back();
    logic [31:0] nv;
    resetn     = 1'b0;
    load_valid = 1'b1;
    load_addr  = BASE + 32'd4;
    load_data  = 32'h0BAD_F00D;
    tick();
    load_valid = 1'b0;
    chk_cnt++;
    if ({instr, running, load_ready, load_cnt, fetch_err} !== {NOP, 1'b0, 1'b1, 16'd0, 1'b0})
      $display("FAIL rerun_reset got instr=%h run=%b rdy=%b cnt=%0d err=%b exp %h 0 1 0 0",
               instr, running, load_ready, load_cnt, fetch_err, NOP);
    else pass_cnt++;
    resetn = 1'b1;
    nv = $urandom;
    load_word(BASE + 32'd8, nv, 1'b1);
    chk_cnt++;
    if ({running, load_ready, load_cnt} !== {1'b1, 1'b0, 16'd1})
      $display("FAIL write_with_done got run=%b rdy=%b cnt=%0d exp 1 0 1",
               running, load_ready, load_cnt);
    else pass_cnt++;
    load_valid = 1'b1;
    load_addr  = BASE + 32'd12;
    load_data  = 32'hCAFE_F00D;
    imem_addr  = BASE + 32'd4;
    tick();
    load_valid = 1'b0;
    imem_addr  = BASE + 32'd8;
    tick();
    chk_cnt++;
    if ({instr, load_cnt} !== {32'h4444_4444, nv, 16'd1})
      $display("FAIL late_write_ignored got instr=%h cnt=%0d exp %h 1",
               instr, load_cnt, {32'h4444_4444, nv});
    else pass_cnt++;
    imem_addr = BASE;
    tick();
    chk_cnt++;
    if ({instr, fetch_err} !== {64'h22222222_11111111, 1'b0})
      $display("FAIL retained_data got instr=%h err=%b exp 2222222211111111 0", instr, fetch_err);
    else pass_cnt++;
    test_random_fetch(20, 1'b0);
  endtask

  initial begin
    chk_cnt    = 0;
    pass_cnt   = 0;
    resetn     = 1'b0;
    imem_addr  = BASE;
    load_valid = 1'b0;
    load_addr  = 32'd0;
    load_data  = 32'd0;
    load_done  = 1'b0;
    test_reset();
    test_first_load();
    test_spec_fetch();
    test_random_fetch(60, 1'b0);
    test_fetch_err();
    test_run_ignores_load();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule

// File: doc/imem_fetch_responder.md
IMEM_FETCH_RESPONDER -- requirements
Module: imem_fetch_responder

Interface
REQ-001 The block SHALL have parameter BASE_ADDR, default 32'h8000_0000, meaning the byte address of instruction word 0.
REQ-002 The block SHALL have parameter DEPTH_WORDS, default 4096 (power of two), meaning the number of 32-bit words held.
REQ-003 The block SHALL have port clk, input, 1, the clock; all state updates on the rising edge.
REQ-004 The block SHALL have port resetn, input, 1, the reset: synchronous, active-low.
REQ-005 The block SHALL have port imem_addr, input, 32, the core fetch byte address.
REQ-006 The block SHALL have port instr, output, 64, the fetch window starting at imem_addr (bits [31:0] = first 32 bits).
REQ-007 The block SHALL have port load_valid, input, 1, a program-load write request.
REQ-008 The block SHALL have port load_ready, output, 1, indicating the block accepts load writes.
REQ-009 The block SHALL have port load_addr, input, 32, the byte address of the load word (word-aligned).
REQ-010 The block SHALL have port load_data, input, 32, the load word.
REQ-011 The block SHALL have port load_done, input, 1, a pulse that ends loading.
REQ-012 The block SHALL have port running, output, 1, high in RUN state.
REQ-013 The block SHALL have port load_cnt, output, 16, the number of accepted load writes (saturating).
REQ-014 The block SHALL have port fetch_err, output, 1, a sticky flag for a misaligned or out-of-range fetch.

Function
REQ-015 The FSM SHALL have states LOAD and RUN; reset enters LOAD; LOAD->RUN on load_done; RUN has no exit except reset.
REQ-016 load_ready SHALL be 1 in LOAD and 0 in RUN; a write occurs only on load_valid & load_ready.
REQ-017 A write SHALL store load_data at word index (load_addr-BASE_ADDR)>>2; an out-of-range load_addr is dropped but still counted; load_addr[1:0] are ignored.
REQ-018 load_cnt SHALL increment on each accepted write and saturate at 16'hFFFF.
REQ-019 If load_valid and load_done coincide in LOAD, the write SHALL complete and the state SHALL move to RUN in the same edge.
REQ-020 In RUN, instr SHALL be registered: the response to imem_addr sampled at edge N appears after edge N (latency 1, a new fetch every cycle).
REQ-021 Let w = (imem_addr-BASE_ADDR)>>2 mod DEPTH_WORDS. If imem_addr[1]=0, instr SHALL be {mem[w+1], mem[w]}.
REQ-022 If imem_addr[1]=1, instr SHALL be {mem[w+2][15:0], mem[w+1], mem[w][31:16]}, so 16-bit compressed and unaligned 32-bit fetches are covered.
REQ-023 The word indices w+1 and w+2 SHALL wrap modulo DEPTH_WORDS.
REQ-024 A fetch SHALL be out of range when imem_addr < BASE_ADDR or imem_addr >= BASE_ADDR + 4*DEPTH_WORDS; it SHALL return NOP pair 64'h00000013_00000013 and set fetch_err.
REQ-025 A fetch with imem_addr[0]=1 SHALL return the NOP pair and set fetch_err.
REQ-026 In LOAD, instr SHALL be the NOP pair and fetch_err SHALL NOT be updated.
REQ-027 Memory contents SHALL NOT be cleared by reset; only registers and the FSM are reset.

Reset
REQ-028 While resetn=0 at an edge: state=LOAD, instr=64'h00000013_00000013, load_cnt=0, fetch_err=0, running=0.
REQ-029 While resetn=0 at an edge, load_ready SHALL be 1 after that edge, and no write SHALL occur in that cycle.
REQ-030 Reset asserted mid-RUN or mid-LOAD SHALL abort the operation in that cycle; the next non-reset cycle behaves as fresh LOAD with prior memory retained.

Verification
REQ-031 The bench SHALL load words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444 at BASE_ADDR, pulse load_done, then fetch BASE_ADDR; the response is instr=0x22222222_11111111, load_cnt=4, running=1.
REQ-032 Using the same data, the bench SHALL fetch BASE_ADDR+2; the response is instr=0x3333_22222222_1111 (64'h33332222_22221111).
REQ-033 The bench SHALL fetch BASE_ADDR+4*DEPTH_WORDS-4 (last word = 0xAAAAAAAA, word 0 = 0x11111111); the response is 0x11111111_AAAAAAAA by wrap, and fetch_err stays 0.
REQ-034 The bench SHALL fetch 0x7FFF_FFFC and BASE_ADDR+1; the response is the NOP pair each time, fetch_err=1 and remaining 1 after subsequent valid fetches.
REQ-035 The bench SHALL assert load_valid with load_done in the same cycle; the response is that the write lands, load_cnt increments, running=1 next cycle, and a later load_valid is ignored.
REQ-036 The bench SHALL assert resetn=0 for 1 cycle in RUN, then refetch BASE_ADDR after a load_done; the response is identical prior data, load_cnt=0, fetch_err=0.
